mul_unpacker: RTL

- Front end of the FP16 multiplier in the systolic-array PE datapath.
- Accepts two IEEE half-precision operands and unpacks sign, exponent and mantissa, restoring the hidden bit.
- Forms the biased exponent sum and computes the 22-bit mantissa product with an iterative shift-add multiplier (one bit per cycle).
- Presents {sign, exponent, mantissa_prod} over a valid/ready handshake to the downstream mul_normalizer input.

---
 rtl/mul_unpacker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mul_unpacker.sv
// mul_unpacker: front end of the FP16 multiplier in the systolic-array PE.
// It takes two half-precision operands, splits them into sign, exponent and
// mantissa, restores the hidden bit, and forms the biased exponent sum. The
// 22-bit mantissa product comes from a shift-add multiplier that handles one
// multiplier bit per cycle. The result {sign, exponent, mantissa_prod} goes
// to mul_normalizer.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   a, b            FP16 operands {sign, exp[4:0], man[9:0]}
//   in_valid        operands valid; in_ready high while idle
//   out_valid       result valid; out_ready is the downstream accept
//   sign            a[15] ^ b[15]
//   exponent        low EXP_W bits of ea + eb - BIAS
//   mantissa_prod   {1,ma} * {1,mb}, or 0 when either operand is zero
//   zero            either operand has an exponent field of 0
//   exp_ovf         true exponent sum > 31
//   exp_unf         true exponent sum < 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data and valid stable until that edge.
// in_ready = (state == IDLE) and out_valid = (state == DONE). Only one
// operation is in flight at a time. Outputs stay stable in DONE for as long
// as out_ready is low.

module mul_unpacker #(
    parameter int BIAS  = 15,
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sign,
    output logic [EXP_W-1:0]           exponent,
    output logic [2*(MAN_W+1)-1:0]     mantissa_prod,
    output logic                       zero,
    output logic                       exp_ovf,
    output logic                       exp_unf
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int SUM_W  = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W + 1);
    localparam logic [SUM_W-1:0] BIAS_V    = SUM_W'(BIAS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MAN_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [SIG_W-1:0]  sig_a;
    logic [SIG_W-1:0]  sig_b;
    logic [SUM_W-1:0]  exp_sum;
    logic              op_zero;
    logic              accept;
    logic              mul_last;

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] acc_sum;
    logic [PROD_W-1:0] multiplicand;
    logic [SIG_W-1:0]  multiplier;
    logic [CNT_W-1:0]  count;

    assign ea      = a[EXP_W+MAN_W-1:MAN_W];
    assign eb      = b[EXP_W+MAN_W-1:MAN_W];
    assign sig_a   = {1'b1, a[MAN_W-1:0]};
    assign sig_b   = {1'b1, b[MAN_W-1:0]};
    // Two extra bits hold the whole range -BIAS .. 2*(2^EXP_W-1)-BIAS in
    // two's complement. The top bit is the sign. Below it, bit EXP_W set on
    // a non-negative sum means the sum is at least 2^EXP_W.
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS_V;
    assign op_zero = (ea == '0) || (eb == '0);
    assign acc_sum = acc + (multiplier[0] ? multiplicand : '0);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mul_last   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = op_zero ? DONE : MUL;
                end
            end
            MUL: begin
                if (count == LAST_STEP) begin
                    mul_last   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign          <= 1'b0;
            exponent      <= '0;
            mantissa_prod <= '0;
            zero          <= 1'b0;
            exp_ovf       <= 1'b0;
            exp_unf       <= 1'b0;
            acc           <= '0;
            multiplicand  <= '0;
            multiplier    <= '0;
            count         <= '0;
        end else begin
            if (accept) begin
                sign <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
                if (op_zero) begin
                    // Subnormals and zeros are both flushed here.
                    zero          <= 1'b1;
                    exponent      <= '0;
                    exp_ovf       <= 1'b0;
                    exp_unf       <= 1'b0;
                    mantissa_prod <= '0;
                end else begin
                    zero         <= 1'b0;
                    exponent     <= exp_sum[EXP_W-1:0];
                    exp_ovf      <= ~exp_sum[SUM_W-1] & exp_sum[EXP_W];
                    exp_unf      <= exp_sum[SUM_W-1];
                    multiplicand <= PROD_W'(sig_a);
                    multiplier   <= sig_b;
                    acc          <= '0;
                    count        <= '0;
                end
            end
            if (state == MUL) begin
                acc          <= acc_sum;
                multiplicand <= multiplicand << 1;
                multiplier   <= multiplier >> 1;
                count        <= count + CNT_W'(1);
                // The last step's partial product goes straight into the
                // result register. There is no extra cycle to read acc back.
                if (mul_last) begin
                    mantissa_prod <= acc_sum;
                end
            end
        end
    end

endmodule
